// File: rtl/ws2812_decoder_if.sv
// Pixel/frame bus of the WS2812 receive decoder: the serial line in,
// decoded pixels and frame summaries out.
interface ws2812_decoder_if #(
  parameter int IDX_W = 8
);
  logic             din;
  logic [23:0]      pixel_data;
  logic             pixel_valid;
  logic [IDX_W-1:0] pixel_index;
  logic             frame_done;
  logic             frame_error;
  logic [IDX_W-1:0] pixel_count;

  modport master (
    output din,
    input  pixel_data, pixel_valid, pixel_index,
    input  frame_done, frame_error, pixel_count
  );

  modport slave (
    input  din,
    output pixel_data, pixel_valid, pixel_index,
    output frame_done, frame_error, pixel_count
  );
endinterface

// File: rtl/ws2812_decoder.sv
// WS2812 NRZ receiver: measures high pulse widths on the synchronised line,
// assembles 24-bit pixels MSB first and reports each frame at the latch gap.
module ws2812_decoder #(
  parameter int NUM_LEDS     = 10,
  parameter int IDX_W        = 8,
  parameter int MIN_HIGH     = 3,
  parameter int BIT_THRESH   = 10,
  parameter int MAX_HIGH     = 20,
  parameter int RESET_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  ws2812_decoder_if.slave    bus
);
  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int LW = $clog2(RESET_CYCLES + 1);

  typedef enum logic [1:0] {WAIT_GAP, READY, HIGH, LOW} state_t;

  logic             s1_q, s_q, prev_q;
  state_t           state_q, state_d;
  logic [HW-1:0]    high_q, high_d;
  logic [LW-1:0]    low_q, low_d;
  logic [4:0]       bit_q, bit_d;
  logic [22:0]      shift_q, shift_d;
  logic             pend_q, pend_d;
  logic [23:0]      word_q, word_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [23:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] pcount_q, pcount_d;

  logic rise, fall, bitv;
  assign rise = s_q & ~prev_q;
  assign fall = ~s_q & prev_q;
  assign bitv = (high_q >= HW'(BIT_THRESH));

  always_comb begin
    state_d  = state_q;
    high_d   = high_q;
    low_d    = low_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pend_d   = 1'b0;
    word_d   = word_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    idx_d    = idx_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    pcount_d = pcount_q;

    // Completed pixel is published one cycle after its last bit is shifted in
    if (pend_q) begin
      data_d = word_q;
      if (cnt_q < IDX_W'(NUM_LEDS)) begin
        valid_d = 1'b1;
        idx_d   = cnt_q;
        cnt_d   = cnt_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    unique case (state_q)
      WAIT_GAP: begin
        if (s_q) begin
          low_d = '0;
        end else if (low_q == LW'(RESET_CYCLES - 1)) begin
          low_d   = '0;
          state_d = READY;
        end else begin
          low_d = low_q + 1'b1;
        end
      end
      READY: begin
        if (rise) begin
          high_d  = HW'(1);
          state_d = HIGH;
        end
      end
      HIGH: begin
        if ((high_q > HW'(MAX_HIGH)) || (fall && (high_q < HW'(MIN_HIGH)))) begin
          err_d   = 1'b1;
          state_d = WAIT_GAP;
          low_d   = '0;
          bit_d   = '0;
          shift_d = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (fall) begin
          // The falling cycle is already the first low cycle of the gap
          shift_d = {shift_q[21:0], bitv};
          low_d   = LW'(1);
          state_d = LOW;
          if (bit_q == 5'd23) begin
            bit_d  = '0;
            pend_d = 1'b1;
            word_d = {shift_q, bitv};
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          high_d = high_q + 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
          high_d  = HW'(1);
          state_d = HIGH;
        end else if (low_q == LW'(RESET_CYCLES - 1)) begin
          done_d   = 1'b1;
          err_d    = (bit_q != 5'd0) | ovf_q;
          pcount_d = cnt_q;
          cnt_d    = '0;
          bit_d    = '0;
          shift_d  = '0;
          ovf_d    = 1'b0;
          low_d    = '0;
          state_d  = READY;
        end else begin
          low_d = low_q + 1'b1;
        end
      end
      default: state_d = WAIT_GAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s_q      <= 1'b0;
      prev_q   <= 1'b0;
      state_q  <= WAIT_GAP;
      high_q   <= '0;
      low_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      pend_q   <= 1'b0;
      word_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      pcount_q <= '0;
    end else begin
      s1_q     <= bus.din;
      s_q      <= s1_q;
      prev_q   <= s_q;
      state_q  <= state_d;
      high_q   <= high_d;
      low_q    <= low_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      pend_q   <= pend_d;
      word_q   <= word_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      err_q    <= err_d;
      pcount_q <= pcount_d;
    end
  end

  assign bus.pixel_data  = data_q;
  assign bus.pixel_valid = valid_q;
  assign bus.pixel_index = idx_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_error = err_q;
  assign bus.pixel_count = pcount_q;
endmodule

// File: tb/tb_ws2812_decoder.sv
// Directed bench for ws2812_decoder: drives NRZ bit streams, logs every
// pixel/frame strobe and compares the log against hand-computed expectations.
module tb_ws2812_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #25 clk = ~clk;

  ws2812_decoder_if #(.IDX_W(8)) bus();

  ws2812_decoder #(
    .NUM_LEDS(10), .IDX_W(8), .MIN_HIGH(3), .BIT_THRESH(10),
    .MAX_HIGH(20), .RESET_CYCLES(1000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [23:0] data; int idx; int cyc; } pix_t;
  typedef struct { bit done; bit err; int cnt; } frm_t;
  typedef struct { logic [23:0] data; bit exp_valid; int exp_idx; } vec_t;

  pix_t pix_q[$];
  frm_t frm_q[$];
  pix_t mp;
  frm_t mf;

  always @(negedge clk) begin
    if (bus.pixel_valid === 1'b1) begin
      mp.data = bus.pixel_data;
      mp.idx  = int'(bus.pixel_index);
      mp.cyc  = cyc;
      pix_q.push_back(mp);
    end
    if (bus.frame_done === 1'b1 || bus.frame_error === 1'b1) begin
      mf.done = bus.frame_done;
      mf.err  = bus.frame_error;
      mf.cnt  = int'(bus.pixel_count);
      frm_q.push_back(mf);
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int tail  = 0;
  int t_fall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    bus.din = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    int h;
    h = b ? 14 : 7;
    drive(1'b1, h);
    t_fall = cyc;
    drive(1'b0, 25 - h);
    tail = 25 - h;
  endtask

  task automatic send_word(input logic [23:0] w, input int nb);
    for (int i = 23; i > 23 - nb; i--) send_bit(w[i]);
  endtask

  // Low time counted from the falling edge of the last bit
  task automatic gap(input int n);
    drive(1'b0, n - tail);
    tail = n;
  endtask

  task automatic settle();
    gap(1000);
    drive(1'b0, 10);
  endtask

  task automatic clear_logs();
    pix_q.delete();
    frm_q.delete();
  endtask

  vec_t tv[12];
  int   k;
  int   tf;

  initial begin
    tv[0]  = '{24'h000001, 1'b1, 0};
    tv[1]  = '{24'h800000, 1'b1, 1};
    tv[2]  = '{24'hFFFFFF, 1'b1, 2};
    tv[3]  = '{24'h000000, 1'b1, 3};
    tv[4]  = '{24'hAAAAAA, 1'b1, 4};
    tv[5]  = '{24'h555555, 1'b1, 5};
    tv[6]  = '{24'h123456, 1'b1, 6};
    tv[7]  = '{24'hFEDCBA, 1'b1, 7};
    tv[8]  = '{24'h0F0F0F, 1'b1, 8};
    tv[9]  = '{24'hF0F0F0, 1'b1, 9};
    tv[10] = '{24'hC0FFEE, 1'b0, 0};
    tv[11] = '{24'hBEEF00, 1'b0, 0};

    bus.din = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pixel_data",  bus.pixel_data,  24'h0);
    check("rst_pixel_valid", bus.pixel_valid, 1'b0);
    check("rst_pixel_index", bus.pixel_index, 8'h0);
    check("rst_frame_done",  bus.frame_done,  1'b0);
    check("rst_frame_error", bus.frame_error, 1'b0);
    check("rst_pixel_count", bus.pixel_count, 8'h0);
    rst_n = 1'b1;
    drive(1'b0, 1000);

    // 1: single pixel, latency
    clear_logs();
    send_word(24'hFF0055, 24);
    tf = t_fall;
    settle();
    check("t1_npix", pix_q.size(), 1);
    if (pix_q.size() >= 1) begin
      check("t1_data",    pix_q[0].data, 24'hFF0055);
      check("t1_index",   pix_q[0].idx,  0);
      check("t1_latency", pix_q[0].cyc,  tf + 4);
    end
    check("t1_nfrm", frm_q.size(), 1);
    if (frm_q.size() >= 1) begin
      check("t1_done", frm_q[0].done, 1);
      check("t1_err",  frm_q[0].err,  0);
      check("t1_cnt",  frm_q[0].cnt,  1);
    end

    // 2: overflow past NUM_LEDS
    clear_logs();
    for (int i = 0; i < 12; i++) send_word(tv[i].data, 24);
    settle();
    check("t2_npix", pix_q.size(), 10);
    k = 0;
    for (int i = 0; i < 12; i++) begin
      if (tv[i].exp_valid && k < pix_q.size()) begin
        check($sformatf("t2_data%0d", i),  pix_q[k].data, tv[i].data);
        check($sformatf("t2_index%0d", i), pix_q[k].idx,  tv[i].exp_idx);
        k++;
      end
    end
    check("t2_nfrm", frm_q.size(), 1);
    if (frm_q.size() >= 1) begin
      check("t2_done", frm_q[0].done, 1);
      check("t2_err",  frm_q[0].err,  1);
      check("t2_cnt",  frm_q[0].cnt,  10);
    end

    // 3: partial pixel
    clear_logs();
    send_word(24'hABC000, 12);
    settle();
    check("t3_npix", pix_q.size(), 0);
    check("t3_nfrm", frm_q.size(), 1);
    if (frm_q.size() >= 1) begin
      check("t3_done", frm_q[0].done, 1);
      check("t3_err",  frm_q[0].err,  1);
      check("t3_cnt",  frm_q[0].cnt,  0);
    end

    // 4: 999-cycle low is not a latch
    clear_logs();
    send_word(24'h00FF00, 24);
    gap(999);
    send_word(24'h5A5A5A, 24);
    settle();
    check("t4_npix", pix_q.size(), 2);
    if (pix_q.size() >= 2) begin
      check("t4_idx0",  pix_q[0].idx,  0);
      check("t4_data0", pix_q[0].data, 24'h00FF00);
      check("t4_idx1",  pix_q[1].idx,  1);
      check("t4_data1", pix_q[1].data, 24'h5A5A5A);
    end
    check("t4_nfrm", frm_q.size(), 1);
    if (frm_q.size() >= 1) begin
      check("t4_err", frm_q[0].err, 0);
      check("t4_cnt", frm_q[0].cnt, 2);
    end

    // 5a: stuck-high abort, following bits ignored
    clear_logs();
    send_word(24'hC3C3C3, 8);
    drive(1'b1, 40);
    drive(1'b0, 10);
    send_word(24'hFFFFFF, 6);
    settle();
    check("t5a_npix", pix_q.size(), 0);
    check("t5a_nfrm", frm_q.size(), 1);
    if (frm_q.size() >= 1) begin
      check("t5a_done", frm_q[0].done, 0);
      check("t5a_err",  frm_q[0].err,  1);
    end
    // 5b: short glitch abort, then a clean pixel
    clear_logs();
    send_word(24'h0F0F0F, 5);
    drive(1'b1, 2);
    drive(1'b0, 1010);
    check("t5b_nfrm", frm_q.size(), 1);
    if (frm_q.size() >= 1) begin
      check("t5b_done", frm_q[0].done, 0);
      check("t5b_err",  frm_q[0].err,  1);
    end
    clear_logs();
    send_word(24'hA5A5A5, 24);
    settle();
    check("t5c_npix", pix_q.size(), 1);
    if (pix_q.size() >= 1) begin
      check("t5c_data",  pix_q[0].data, 24'hA5A5A5);
      check("t5c_index", pix_q[0].idx,  0);
    end
    check("t5c_nfrm", frm_q.size(), 1);
    if (frm_q.size() >= 1) check("t5c_cnt", frm_q[0].cnt, 1);

    // 6: reset mid-pixel
    send_word(24'h987654, 10);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_data",  bus.pixel_data,  24'h0);
    check("t6_rst_count", bus.pixel_count, 8'h0);
    check("t6_rst_valid", bus.pixel_valid, 1'b0);
    clear_logs();
    rst_n = 1'b1;
    send_word(24'h987654 << 10, 14);
    settle();
    check("t6_npix_pre", pix_q.size(), 0);
    check("t6_nfrm_pre", frm_q.size(), 0);
    send_word(24'h123456, 24);
    settle();
    check("t6_npix", pix_q.size(), 1);
    if (pix_q.size() >= 1) begin
      check("t6_data",  pix_q[0].data, 24'h123456);
      check("t6_index", pix_q[0].idx,  0);
    end
    check("t6_nfrm", frm_q.size(), 1);
    if (frm_q.size() >= 1) begin
      check("t6_err", frm_q[0].err, 0);
      check("t6_cnt", frm_q[0].cnt, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ws2812_decoder.md
Name: ws2812_decoder

Overview:
Receive-side counterpart of the LED driver: samples a single-wire WS2812 NRZ stream and recovers 24-bit pixel words, MSB first, in wire order. Used for loopback checking of the LED driver output in hardware and as the capture front end for a chained-strip monitor. Emits one strobe per pixel, then a frame summary when the latch (reset) gap is detected. Timing defaults assume the 20 MHz system clock (50 ns).

Parameters:
NUM_LEDS, 10, maximum pixels accepted per frame; further pixels are dropped.
IDX_W, 8, width of pixel_index and pixel_count; must satisfy 2^IDX_W > NUM_LEDS.
MIN_HIGH, 3, high pulses shorter than this many cycles are errors (glitch).
BIT_THRESH, 10, high pulse of at least this many cycles decodes as 1, otherwise 0.
MAX_HIGH, 20, high pulse longer than this many cycles is an error.
RESET_CYCLES, 1000, low time in cycles that marks the latch gap (50 us).

Ports:
clk  in  1  system clock, 20 MHz
reset  in  1  asynchronous reset, active-low (0 = in reset)
din  in  1  WS2812 serial line, asynchronous to clk
pixel_data  out  24  last decoded pixel, held until the next one
pixel_valid  out  1  one-cycle strobe, pixel_data/pixel_index valid
pixel_index  out  IDX_W  position of the pixel in the current frame, from 0
frame_done  out  1  one-cycle strobe at end of frame
frame_error  out  1  one-cycle strobe, same cycle as frame_done or on abort
pixel_count  out  IDX_W  pixels accepted in the last frame; valid on frame_done, held

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, counters 0, synchroniser cleared to 0, state WAIT_GAP.
- din passes through a 2-flop synchroniser; all edge logic runs on the synchronised value s.
- Counters: high_cnt saturates at MAX_HIGH+1; low_cnt saturates at RESET_CYCLES; bit_cnt 0..23; pixel counter saturates at NUM_LEDS.
- States:
  - WAIT_GAP: ignore data. Count consecutive low cycles, restarting on any high. At RESET_CYCLES go to READY with no strobes. Entered after reset and after any error abort.
  - READY: line is idle low. A rising edge on s goes to HIGH with high_cnt=1.
  - HIGH: increment high_cnt each cycle.
    - If high_cnt exceeds MAX_HIGH: pulse frame_error (no frame_done), discard partial pixel and frame, go to WAIT_GAP.
    - On a falling edge:
      - If high_cnt < MIN_HIGH: treat as the same error.
      - Otherwise shift in bit (1 iff high_cnt >= BIT_THRESH), clear low_cnt, go to LOW.
  - LOW: increment low_cnt.
    - A rising edge goes to HIGH.
    - If low_cnt reaches RESET_CYCLES, end the frame (below), reset frame counters, go to READY.
- Pixel completion:
  - When the 24th bit is shifted in: pixel_data <= shift word.
  - If fewer than NUM_LEDS pixels have been accepted this frame: pulse pixel_valid with pixel_index = accepted count, then increment the count.
  - Otherwise drop the pixel (no pixel_valid) and mark overflow.
- Latency: pixel_valid asserts exactly 3 clk cycles after the first clk edge that samples din low at the end of the 24th bit (2 synchroniser + 1 decode).
- End of frame: pulse frame_done and set pixel_count = accepted count. Pulse frame_error in the same cycle if bit_cnt != 0 (partial pixel) or overflow was marked.
- A low gap of RESET_CYCLES-1 cycles is not a latch; decoding continues across it.
- Between frames in READY: no strobes, outputs hold.
- Reset mid-frame: everything is discarded. After release the block must see a full RESET_CYCLES low before decoding.

Test Plan:
1. Release reset, hold din low 1000 cycles, send 0xFF0055 (T0H=7 and T1H=14 cycles, 25-cycle bit period), then 1000 low cycles -> one pixel_valid with pixel_data=0xFF0055 and pixel_index=0. Then frame_done with pixel_count=1 and frame_error=0. Check the 3-cycle latency.
2. Send 12 back-to-back pixels with NUM_LEDS=10, then a gap -> 10 pixel_valid strobes with indices 0..9 and data matching. frame_done with pixel_count=10 and frame_error=1.
3. Send 12 bits, then a 1000-cycle low -> no pixel_valid; frame_done and frame_error in the same cycle; pixel_count=0.
4. Send 1 pixel, a 999-cycle low, then 1 pixel and a 1000-cycle low -> indices 0 and 1; a single frame_done with pixel_count=2.
5. Hold din high 40 cycles mid-pixel; separately send a 2-cycle high glitch -> frame_error pulse, no frame_done. Bits are ignored until 1000 low cycles, then a new pixel decodes at index 0.
6. Assert reset after 10 bits of a pixel, release, and resume bits immediately -> outputs 0, nothing decoded. After a 1000-cycle low, 0x123456 decodes at index 0.
